// File: rtl/clkdiv_bank.sv
// clkdiv_bank: NCH independent programmable clock dividers sharing one clock.
// Each channel makes a one-cycle tick and a near-50% square wave every D cycles,
// with per-channel run enable, runtime divisor reload and a group phase-align.

// One divider channel. Outputs are registered from the next counter value so
// downstream logic never sees a combinational path from the counter.
module clkdiv_ch #(
   parameter int               CNT_W   = 24,
   parameter logic [CNT_W-1:0] DIV_RST = '0
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             i_en,
   input  logic             i_ld,
   input  logic [CNT_W-1:0] i_ld_div,
   input  logic             i_align,
   output logic             o_tick,
   output logic             o_clk_out,
   output logic [CNT_W-1:0] o_div
);
   logic [CNT_W-1:0] r_cnt, r_div;
   logic             r_tick, r_clk;
   logic [CNT_W-1:0] w_dm1, w_hi_th, w_cnt_nxt;

   // Last count of a period, and the count at which the square wave goes high
   // (high for floor(D/2) cycles at the end of each period).
   assign w_dm1   = r_div - CNT_W'(1);
   assign w_hi_th = r_div - (r_div >> 1);

   // Wrap at D-1; the >= also recovers cleanly if cnt were ever past D-1.
   always_comb begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
      if (r_cnt >= w_dm1) w_cnt_nxt = '0;
   end

   // Counter, divisor and output registers; restart > halt (D=0) > hold > count.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_cnt  <= '0;
         r_div  <= DIV_RST;
         r_tick <= 1'b0;
         r_clk  <= 1'b0;
      end else if (i_ld || i_align) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
         r_clk  <= 1'b0;
         if (i_ld) r_div <= i_ld_div;
      end else if (r_div == '0) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
         r_clk  <= 1'b0;
      end else if (!i_en) begin
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_tick <= (w_cnt_nxt == w_dm1);
         r_clk  <= (w_cnt_nxt >= w_hi_th);
      end
   end

   assign o_tick    = r_tick;
   assign o_clk_out = r_clk;
   assign o_div     = r_div;
endmodule

module clkdiv_bank #(
   parameter int                     NCH      = 4,
   parameter int                     CNT_W    = 24,
   parameter logic [NCH*CNT_W-1:0]   DIV_INIT = {24'd1000, 24'd2, 24'h100000, 24'd4}
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic [NCH-1:0]       ch_en,
   input  logic                 load,
   input  logic [3:0]           load_ch,
   input  logic [CNT_W-1:0]     load_div,
   input  logic                 align,
   output logic [NCH-1:0]       tick,
   output logic [NCH-1:0]       clk_out,
   output logic [NCH*CNT_W-1:0] div_q
);
   logic [NCH-1:0] w_ld;

   // Out-of-range load_ch matches no channel, so such a load is a no-op.
   for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign w_ld[g] = load && (load_ch == 4'(g));

      clkdiv_ch #(
         .CNT_W   (CNT_W),
         .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
      ) u_ch (
         .clk       (clk),
         .clr_n     (clr_n),
         .i_en      (ch_en[g]),
         .i_ld      (w_ld[g]),
         .i_ld_div  (load_div),
         .i_align   (align),
         .o_tick    (tick[g]),
         .o_clk_out (clk_out[g]),
         .o_div     (div_q[g*CNT_W +: CNT_W])
      );
   end
endmodule

// File: tb/tb_clkdiv_bank.sv
// Directed bench for clkdiv_bank with default parameters (NCH=4, CNT_W=24).
module tb_clkdiv_bank;
   localparam int NCH = 4;
   localparam int CW  = 24;
   localparam logic [NCH*CW-1:0] EXP_INIT = {24'd1000, 24'd2, 24'h100000, 24'd4};

   logic              clk = 1'b0;
   logic              clr_n;
   logic [NCH-1:0]    ch_en;
   logic              load;
   logic [3:0]        load_ch;
   logic [CW-1:0]     load_div;
   logic              align;
   logic [NCH-1:0]    tick;
   logic [NCH-1:0]    clk_out;
   logic [NCH*CW-1:0] div_q;

   int n_cmp = 0;
   int n_err = 0;

   // Expected vectors for edges 1..8 after reset release with default divisors
   logic [3:0] t1_tick [1:8] = '{4'b0100, 4'b0000, 4'b0101, 4'b0000,
                                 4'b0100, 4'b0000, 4'b0101, 4'b0000};
   logic [3:0] t1_clk  [1:8] = '{4'b0100, 4'b0001, 4'b0101, 4'b0000,
                                 4'b0100, 4'b0001, 4'b0101, 4'b0000};
   // ch0 D=5 after load, edges 1..10 at bit k-1
   logic [9:0] t2_tick = 10'b0100001000;
   logic [9:0] t2_clk  = 10'b0110001100;
   // after align + load ch1 D=6, edges 1..5
   logic [3:0] t4_tick [1:5] = '{4'b0100, 4'b0000, 4'b0101, 4'b0000, 4'b0110};
   logic [3:0] t4_clk  [1:5] = '{4'b0100, 4'b0001, 4'b0111, 4'b0010, 4'b0110};

   clkdiv_bank dut (
      .clk      (clk),
      .clr_n    (clr_n),
      .ch_en    (ch_en),
      .load     (load),
      .load_ch  (load_ch),
      .load_div (load_div),
      .align    (align),
      .tick     (tick),
      .clk_out  (clk_out),
      .div_q    (div_q)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_defaults(input string pfx);
      for (int k = 1; k <= 8; k++) begin
         step();
         chk($sformatf("%s_tick_e%0d", pfx, k), 128'(tick), 128'(t1_tick[k]));
         chk($sformatf("%s_clk_e%0d", pfx, k), 128'(clk_out), 128'(t1_clk[k]));
      end
   endtask

   task automatic load_ch0(input logic [CW-1:0] d);
      load = 1'b1; load_ch = 4'd0; load_div = d;
      step();
      load = 1'b0;
      chk("ld_div", 128'(div_q[CW-1:0]), 128'(d));
      chk("ld_tick", 128'(tick[0]), 128'(0));
      chk("ld_clk", 128'(clk_out[0]), 128'(0));
   endtask

   initial begin
      clr_n = 1'b0; ch_en = 4'hF; load = 1'b0; load_ch = '0; load_div = '0; align = 1'b0;

      // 1: reset state and default divisor behaviour
      #12;
      chk("rst_tick", 128'(tick), 128'(0));
      chk("rst_clk", 128'(clk_out), 128'(0));
      chk("rst_div", 128'(div_q), 128'(EXP_INIT));
      #1 clr_n = 1'b1;
      run_defaults("t1");

      // 2: ch0 D=5, then D=1, then D=0
      load_ch0(24'd5);
      for (int k = 1; k <= 10; k++) begin
         step();
         chk($sformatf("d5_tick_e%0d", k), 128'(tick[0]), 128'(t2_tick[k-1]));
         chk($sformatf("d5_clk_e%0d", k), 128'(clk_out[0]), 128'(t2_clk[k-1]));
      end
      load_ch0(24'd1);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("d1_tick_e%0d", k), 128'(tick[0]), 128'(1));
         chk($sformatf("d1_clk_e%0d", k), 128'(clk_out[0]), 128'(0));
      end
      load_ch0(24'd0);
      ch_en[0] = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("d0_tick_e%0d", k), 128'(tick[0]), 128'(0));
         chk($sformatf("d0_clk_e%0d", k), 128'(clk_out[0]), 128'(0));
      end

      // 3: pause ch0 (D=4) at cnt=1, then at cnt=2 where clk_out is high
      load_ch0(24'd4);
      step();                                   // cnt=1
      ch_en[0] = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         chk($sformatf("p1_tick_%0d", k), 128'(tick[0]), 128'(0));
         chk($sformatf("p1_clk_%0d", k), 128'(clk_out[0]), 128'(0));
      end
      ch_en[0] = 1'b1;
      step();                                   // cnt=2
      chk("p1_res1_tick", 128'(tick[0]), 128'(0));
      chk("p1_res1_clk", 128'(clk_out[0]), 128'(1));
      step();                                   // cnt=3
      chk("p1_res2_tick", 128'(tick[0]), 128'(1));
      step(); step(); step();                   // cnt=0,1,2
      chk("p2_pre_clk", 128'(clk_out[0]), 128'(1));
      ch_en[0] = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("p2_tick_%0d", k), 128'(tick[0]), 128'(0));
         chk($sformatf("p2_clk_%0d", k), 128'(clk_out[0]), 128'(1));
      end
      ch_en[0] = 1'b1;
      step();                                   // cnt=3
      chk("p2_res_tick", 128'(tick[0]), 128'(1));

      // 4: align with a same-edge load of ch1 D=6
      align = 1'b1; load = 1'b1; load_ch = 4'd1; load_div = 24'd6;
      step();
      align = 1'b0; load = 1'b0;
      chk("al_tick", 128'(tick), 128'(0));
      chk("al_clk", 128'(clk_out), 128'(0));
      chk("al_div1", 128'(div_q[2*CW-1:CW]), 128'(6));
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("al_tick_e%0d", k), 128'(tick), 128'(t4_tick[k]));
         chk($sformatf("al_clk_e%0d", k), 128'(clk_out), 128'(t4_clk[k]));
      end

      // 5: out-of-range load_ch is ignored
      load = 1'b1; load_ch = 4'd9; load_div = 24'd7;
      step();
      load = 1'b0;
      chk("oor_div", 128'(div_q), 128'({24'd1000, 24'd2, 24'd6, 24'd4}));
      chk("oor_tick_e6", 128'(tick), 128'(4'b0000));
      chk("oor_clk_e6", 128'(clk_out), 128'(4'b0001));
      step();
      chk("oor_tick_e7", 128'(tick), 128'(4'b0101));
      chk("oor_clk_e7", 128'(clk_out), 128'(4'b0101));

      // 6: asynchronous reset mid-period restores DIV_INIT
      #2 clr_n = 1'b0;
      #1;
      chk("arst_tick", 128'(tick), 128'(0));
      chk("arst_clk", 128'(clk_out), 128'(0));
      chk("arst_div", 128'(div_q), 128'(EXP_INIT));
      #1 clr_n = 1'b1;
      run_defaults("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
